// File: rtl/game_pkg.sv
// Shared types for the factorization-quiz game controller:
// FSM state codes (visible on STATE) and judge result codes.
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_READY    = 4'd1,
        ST_QUESTION = 4'd2,
        ST_INPUT    = 4'd3,
        ST_JUDGE    = 4'd4,
        ST_CORRECT  = 4'd5,
        ST_WRONG    = 4'd6,
        ST_CLEAR    = 4'd7,
        ST_GAMEOVER = 4'd8
    } state_e;

    // 2'b11 is a legal bus value that the controller ignores.
    typedef enum logic [1:0] {
        JUDG_PEND = 2'b00,
        JUDG_OK   = 2'b01,
        JUDG_NG   = 2'b10
    } judg_e;

endpackage

// File: rtl/game_ctrl_param_if.sv
// Signal bundle between the quiz front end / question generator / judge (master)
// and the game controller (slave).
interface game_ctrl_param_if #(
    parameter int SEL_W = 3,
    parameter int HP_W  = 2
);
    logic             READY_IN;
    logic             OK_IN;
    logic             QUE_IN;
    logic [SEL_W-1:0] SEL;
    logic             DEC;
    logic             CLR_IN;
    logic [1:0]       JUDG_IN;

    logic             READY_OUT;
    logic [3:0]       STATE;
    logic [SEL_W-1:0] SEL_OUT;
    logic             DEC_OUT;
    logic             CLR_OUT;
    logic [HP_W-1:0]  HP_OUT;
    logic [7:0]       Q_CNT;
    logic [7:0]       TIME_LEFT;

    modport master (
        output READY_IN, OK_IN, QUE_IN, SEL, DEC, CLR_IN, JUDG_IN,
        input  READY_OUT, STATE, SEL_OUT, DEC_OUT, CLR_OUT, HP_OUT, Q_CNT, TIME_LEFT
    );

    modport slave (
        input  READY_IN, OK_IN, QUE_IN, SEL, DEC, CLR_IN, JUDG_IN,
        output READY_OUT, STATE, SEL_OUT, DEC_OUT, CLR_OUT, HP_OUT, Q_CNT, TIME_LEFT
    );
endinterface

// File: rtl/sec_timer.sv
// Per-question answer timer: a SEC_DIV-cycle divider producing one-second ticks
// that count TIME_LEFT down from TIME_LIMIT and flag a one-cycle timeout.
module sec_timer #(
    parameter int SEC_DIV    = 50_000_000,
    parameter int TIME_LIMIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       enable,
    output logic [7:0] time_left,
    output logic       timeout
);
    localparam int DIV_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick = enable && (div == DIV_W'(SEC_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            time_left <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (load) begin
                div       <= '0;
                time_left <= 8'(TIME_LIMIT);
            end else if (enable) begin
                div <= tick ? '0 : div + DIV_W'(1);
                // With TIME_LIMIT==0 time_left sits at 0, so ticks are never acted on.
                if (tick && time_left != 8'd0) begin
                    time_left <= time_left - 8'd1;
                    timeout   <= (time_left == 8'd1);
                end
            end
        end
    end
endmodule

// File: rtl/game_ctrl_param.sv
// Game-flow controller for the factorization quiz: sequences start, question,
// answer entry with time limit, judging, HP loss and clear / game over.
module game_ctrl_param
    import game_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int HP_W       = 2,
    parameter int HP_INIT    = 3,
    parameter int NUM_Q      = 4,
    parameter int TIME_LIMIT = 10,
    parameter int SEC_DIV    = 50_000_000
) (
    input logic              CLK,
    input logic              RST,
    game_ctrl_param_if.slave bus
);
    state_e           state, state_nxt;
    logic [HP_W-1:0]  hp, hp_nxt, hp_dec;
    logic [7:0]       q_cnt, q_nxt, q_inc;
    logic [SEL_W-1:0] sel_q, sel_nxt;
    logic             dec_q, dec_edge;
    logic             ready_q, clr_q, dec_out_q;
    logic             timer_load, timer_en, timeout;

    assign dec_edge   = bus.DEC && !dec_q;
    assign hp_dec     = (hp == '0) ? '0 : hp - HP_W'(1);
    assign q_inc      = q_cnt + 8'd1;
    assign timer_load = (state == ST_QUESTION) && bus.QUE_IN;
    assign timer_en   = (state == ST_INPUT);

    sec_timer #(
        .SEC_DIV   (SEC_DIV),
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (timer_load),
        .enable   (timer_en),
        .time_left(bus.TIME_LEFT),
        .timeout  (timeout)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        hp_nxt    = hp;
        q_nxt     = q_cnt;
        sel_nxt   = sel_q;
        case (state)
            ST_IDLE: if (bus.READY_IN) begin
                state_nxt = ST_READY;
                hp_nxt    = HP_W'(HP_INIT);
                q_nxt     = '0;
            end
            ST_READY:    if (bus.OK_IN) state_nxt = ST_QUESTION;
            ST_QUESTION: if (bus.QUE_IN) begin
                state_nxt = ST_INPUT;
                sel_nxt   = '0;
            end
            ST_INPUT: begin
                sel_nxt = bus.CLR_IN ? '0 : bus.SEL;
                // A decide edge beats a timeout arriving in the same cycle.
                if (dec_edge)     state_nxt = ST_JUDGE;
                else if (timeout) state_nxt = ST_WRONG;
            end
            ST_JUDGE: begin
                if (bus.JUDG_IN == JUDG_OK)      state_nxt = ST_CORRECT;
                else if (bus.JUDG_IN == JUDG_NG) state_nxt = ST_WRONG;
            end
            ST_CORRECT: begin
                q_nxt     = q_inc;
                state_nxt = (q_inc == 8'(NUM_Q)) ? ST_CLEAR : ST_QUESTION;
            end
            ST_WRONG: begin
                hp_nxt = hp_dec;
                q_nxt  = q_inc;
                if (hp_dec == '0)               state_nxt = ST_GAMEOVER;
                else if (q_inc == 8'(NUM_Q))    state_nxt = ST_CLEAR;
                else                            state_nxt = ST_QUESTION;
            end
            ST_CLEAR, ST_GAMEOVER: if (bus.READY_IN) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            hp        <= '0;
            q_cnt     <= '0;
            sel_q     <= '0;
            dec_q     <= 1'b0;
            ready_q   <= 1'b0;
            clr_q     <= 1'b0;
            dec_out_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            hp        <= hp_nxt;
            q_cnt     <= q_nxt;
            sel_q     <= sel_nxt;
            dec_q     <= bus.DEC;
            // Flag outputs are registered from the next state so they line up with STATE.
            ready_q   <= (state_nxt == ST_READY);
            clr_q     <= (state_nxt == ST_CLEAR);
            dec_out_q <= (state == ST_INPUT) && dec_edge;
        end
    end

    assign bus.STATE     = state;
    assign bus.READY_OUT = ready_q;
    assign bus.SEL_OUT   = sel_q;
    assign bus.DEC_OUT   = dec_out_q;
    assign bus.CLR_OUT   = clr_q;
    assign bus.HP_OUT    = hp;
    assign bus.Q_CNT     = q_cnt;
endmodule

// File: tb/tb_game_ctrl_param.sv
// Self-checking bench: two controllers (NUM_Q=2/HP_INIT=2 and NUM_Q=1/HP_INIT=1) share
// stimulus and are compared every cycle against a behavioural game model.
module tb_game_ctrl_param;
    localparam int SD = 4;
    localparam int TL = 3;

    logic       CLK, RST;
    logic       ready_in, ok_in, que_in, dec, clr_in;
    logic [2:0] sel;
    logic [1:0] judg;
    int         checks = 0;
    int         errors = 0;
    bit         cmp_en = 0;

    game_ctrl_param_if #(.SEL_W(3), .HP_W(2)) bus0 ();
    game_ctrl_param_if #(.SEL_W(3), .HP_W(2)) bus1 ();

    assign bus0.READY_IN = ready_in;  assign bus1.READY_IN = ready_in;
    assign bus0.OK_IN    = ok_in;     assign bus1.OK_IN    = ok_in;
    assign bus0.QUE_IN   = que_in;    assign bus1.QUE_IN   = que_in;
    assign bus0.SEL      = sel;       assign bus1.SEL      = sel;
    assign bus0.DEC      = dec;       assign bus1.DEC      = dec;
    assign bus0.CLR_IN   = clr_in;    assign bus1.CLR_IN   = clr_in;
    assign bus0.JUDG_IN  = judg;      assign bus1.JUDG_IN  = judg;

    game_ctrl_param #(.SEL_W(3), .HP_W(2), .HP_INIT(2), .NUM_Q(2), .TIME_LIMIT(TL), .SEC_DIV(SD))
        u0 (.CLK(CLK), .RST(RST), .bus(bus0));
    game_ctrl_param #(.SEL_W(3), .HP_W(2), .HP_INIT(1), .NUM_Q(1), .TIME_LIMIT(TL), .SEC_DIV(SD))
        u1 (.CLK(CLK), .RST(RST), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Game model: n counts edges spent in answer entry; seconds left is TL - n/SD.
    typedef struct {
        int         st;
        int         hp;
        int         q;
        int         n;
        int         left;
        logic [2:0] sel;
        bit         dec_prev;
        bit         dec_pulse;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.hp = 0; r.q = 0; r.n = 0; r.left = 0;
        r.sel = '0; r.dec_prev = 0; r.dec_pulse = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int num_q, int hp_init);
        mdl_t r = m;
        bit pressed = dec && !m.dec_prev;
        bit expired = (TL != 0) && (m.st == 3) && (m.n == TL * SD);
        r.dec_prev  = dec;
        r.dec_pulse = 0;
        case (m.st)
            0: if (ready_in) begin r.st = 1; r.hp = hp_init; r.q = 0; end
            1: if (ok_in) r.st = 2;
            2: if (que_in) begin r.st = 3; r.n = 0; r.left = TL; r.sel = '0; end
            3: begin
                r.sel  = clr_in ? 3'd0 : sel;
                r.n    = m.n + 1;
                r.left = (TL - r.n / SD > 0) ? TL - r.n / SD : 0;
                if (pressed) begin r.st = 4; r.dec_pulse = 1; end
                else if (expired) r.st = 6;
            end
            4: if (judg == 2'd1) r.st = 5; else if (judg == 2'd2) r.st = 6;
            5: begin r.q = m.q + 1; r.st = (r.q == num_q) ? 7 : 2; end
            6: begin
                r.hp = (m.hp > 0) ? m.hp - 1 : 0;
                r.q  = m.q + 1;
                r.st = (r.hp == 0) ? 8 : ((r.q == num_q) ? 7 : 2);
            end
            default: if (ready_in) r.st = 0;
        endcase
        return r;
    endfunction

    initial begin
        m0 = mreset();
        m1 = mreset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                m0 = mreset();
                m1 = mreset();
            end else begin
                m0 = mstep(m0, 2, 2);
                m1 = mstep(m1, 1, 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic [3:0] st, input logic rdy, input logic [2:0] so,
                       input logic dout, input logic cout, input logic [1:0] hp,
                       input logic [7:0] q, input logic [7:0] tl, input mdl_t m);
        check({tag, ".STATE"},     32'(st),   32'(m.st));
        check({tag, ".READY_OUT"}, 32'(rdy),  32'(m.st == 1));
        check({tag, ".SEL_OUT"},   32'(so),   32'(m.sel));
        check({tag, ".DEC_OUT"},   32'(dout), 32'(m.dec_pulse));
        check({tag, ".CLR_OUT"},   32'(cout), 32'(m.st == 7));
        check({tag, ".HP_OUT"},    32'(hp),   32'(m.hp));
        check({tag, ".Q_CNT"},     32'(q),    32'(m.q));
        check({tag, ".TIME_LEFT"}, 32'(tl),   32'(m.left));
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                cmp("u0", bus0.STATE, bus0.READY_OUT, bus0.SEL_OUT, bus0.DEC_OUT, bus0.CLR_OUT,
                    bus0.HP_OUT, bus0.Q_CNT, bus0.TIME_LEFT, m0);
                cmp("u1", bus1.STATE, bus1.READY_OUT, bus1.SEL_OUT, bus1.DEC_OUT, bus1.CLR_OUT,
                    bus1.HP_OUT, bus1.Q_CNT, bus1.TIME_LEFT, m1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic start_question();
        ready_in = 1; tick(); ready_in = 0;
        ok_in = 1;    tick(); ok_in = 0;
        que_in = 1;   tick(); que_in = 0;
    endtask

    initial begin
        int dec_rate;
        RST = 0; ready_in = 0; ok_in = 0; que_in = 0; dec = 0; clr_in = 0; sel = '0; judg = '0;
        tick(2);
        cmp_en = 1;
        check("rst_state", 32'(bus0.STATE), 0);
        check("rst_hp", 32'(bus0.HP_OUT), 0);
        check("rst_tl", 32'(bus0.TIME_LEFT), 0);
        RST = 1;

        // Start and first question
        ready_in = 1; tick(); ready_in = 0;
        check("start_state", 32'(bus0.STATE), 1);
        check("start_hp", 32'(bus0.HP_OUT), 2);
        check("start_ready", 32'(bus0.READY_OUT), 1);
        ok_in = 1;  tick(); ok_in = 0;
        que_in = 1; tick(); que_in = 0;
        check("input_state", 32'(bus0.STATE), 3);
        check("input_tl", 32'(bus0.TIME_LEFT), 3);
        sel = 3'd5; tick();
        check("sel_follow", 32'(bus0.SEL_OUT), 5);
        clr_in = 1; tick(); clr_in = 0;
        check("sel_clear", 32'(bus0.SEL_OUT), 0);
        dec = 1; tick();
        check("dec_judge", 32'(bus0.STATE), 4);
        check("dec_pulse", 32'(bus0.DEC_OUT), 1);
        tick(); dec = 0;
        check("dec_pulse_end", 32'(bus0.DEC_OUT), 0);

        // Two correct answers clear the game
        judg = 2'd1; tick(); judg = 0;
        check("correct_state", 32'(bus0.STATE), 5);
        tick();
        check("q_after_1", 32'(bus0.Q_CNT), 1);
        que_in = 1; tick(); que_in = 0;
        dec = 1; tick(); dec = 0;
        judg = 2'd1; tick(); judg = 0;
        tick();
        check("clear_state", 32'(bus0.STATE), 7);
        check("clear_q", 32'(bus0.Q_CNT), 2);
        check("clear_out", 32'(bus0.CLR_OUT), 1);
        ready_in = 1; tick(); ready_in = 0;
        check("clear_to_idle", 32'(bus0.STATE), 0);

        // Timeout without any decide
        start_question();
        check("tmo_tl3", 32'(bus0.TIME_LEFT), 3);
        tick(4);
        check("tmo_tl2", 32'(bus0.TIME_LEFT), 2);
        tick(4);
        check("tmo_tl1", 32'(bus0.TIME_LEFT), 1);
        tick(4);
        check("tmo_pulse_state", 32'(bus0.STATE), 3);
        tick();
        check("tmo_wrong", 32'(bus0.STATE), 6);
        tick();
        check("tmo_hp", 32'(bus0.HP_OUT), 1);
        check("tmo_next_q", 32'(bus0.STATE), 2);
        check("u1_tmo_over", 32'(bus1.STATE), 8);

        // Second wrong answer: game over beats clear
        que_in = 1; tick(); que_in = 0;
        dec = 1; tick(); dec = 0;
        judg = 2'd2; tick(); judg = 0;
        tick();
        check("over_state", 32'(bus0.STATE), 8);
        check("over_hp", 32'(bus0.HP_OUT), 0);
        check("over_clr", 32'(bus0.CLR_OUT), 0);

        // Single wrong answer with NUM_Q=1, HP_INIT=1
        ready_in = 1; tick();
        start_question();
        dec = 1; tick(); dec = 0;
        judg = 2'd2; tick(); judg = 0;
        tick();
        check("u1_over_state", 32'(bus1.STATE), 8);
        check("u1_over_q", 32'(bus1.Q_CNT), 1);
        check("u1_over_clr", 32'(bus1.CLR_OUT), 0);
        check("u0_survive_hp", 32'(bus0.HP_OUT), 1);

        // Asynchronous reset during JUDGE
        que_in = 1; tick(); que_in = 0;
        dec = 1; tick(); dec = 0;
        check("pre_rst_judge", 32'(bus0.STATE), 4);
        #2 RST = 0;
        #1;
        check("arst_state", 32'(bus0.STATE), 0);
        check("arst_dec_out", 32'(bus0.DEC_OUT), 0);
        check("arst_hp", 32'(bus0.HP_OUT), 0);
        check("arst_q", 32'(bus0.Q_CNT), 0);
        check("arst_tl", 32'(bus0.TIME_LEFT), 0);
        @(negedge CLK);
        RST = 1;

        // Decide edge in the timeout cycle wins
        start_question();
        tick(12);
        check("race_pulse_state", 32'(bus0.STATE), 3);
        dec = 1; tick(); dec = 0;
        check("race_judge", 32'(bus0.STATE), 4);
        check("race_dec_out", 32'(bus0.DEC_OUT), 1);

        // Randomised play checked by the model every cycle
        dec_rate = 6;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dec_rate = ($urandom_range(0, 1) == 0) ? 6 : 40;
            ready_in = ($urandom_range(0, 3) == 0);
            ok_in    = ($urandom_range(0, 2) == 0);
            que_in   = ($urandom_range(0, 2) == 0);
            sel      = 3'($urandom_range(0, 7));
            dec      = ($urandom_range(0, dec_rate - 1) == 0);
            clr_in   = ($urandom_range(0, 7) == 0);
            judg     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                #2 RST = 0;
                #2 RST = 1;
            end
            tick();
        end

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_ctrl_param.md
# game_ctrl_param

Parametrised game-flow controller for the factorization quiz. It sequences start, question fetch, answer entry, judging, HP loss and game clear/over. It sits between the button/switch front end, the question generator and the answer judge. Compared with the fixed controller, it adds configurable selection width, HP, question count and a per-question answer time limit driven by an internal one-second timer.

## Interface
- SEL_W, 3: width of the answer-selection bus
- HP_W, 2: width of the HP counter
- HP_INIT, 3: HP loaded at game start (1..2^HP_W-1)
- NUM_Q, 4: questions per game (1..255)
- TIME_LIMIT, 10: seconds allowed per answer; 0 disables the timeout
- SEC_DIV, 50_000_000: CLK cycles per second

Ports:
- CLK  in  1  system clock, all state changes on its rising edge
- RST  in  1  reset, asynchronous, active-low
- READY_IN  in  1  start/restart request (level, sampled)
- OK_IN  in  1  question generator has a question ready
- QUE_IN  in  1  question is displayed, answer entry may begin
- SEL  in  SEL_W  current answer selection
- DEC  in  1  decide button (synchronised level)
- CLR_IN  in  1  clear current selection
- JUDG_IN  in  2  judge result: 00 pending, 01 correct, 10 wrong, 11 ignored
- READY_OUT  out  1  high in READY
- STATE  out  4  current state code
- SEL_OUT  out  SEL_W  latched selection
- DEC_OUT  out  1  one-cycle pulse requesting judgement
- CLR_OUT  out  1  high in CLEAR (game won)
- HP_OUT  out  HP_W  remaining HP
- Q_CNT  out  8  questions completed this game
- TIME_LEFT  out  8  seconds remaining in INPUT

## Operation
- States and codes:
  - IDLE=0: READY_IN=1 -> READY. Loads HP_OUT=HP_INIT and clears Q_CNT.
  - READY=1: OK_IN=1 -> QUESTION.
  - QUESTION=2: QUE_IN=1 -> INPUT. Loads TIME_LEFT=TIME_LIMIT, clears the divider and clears SEL_OUT.
  - INPUT=3:
    - SEL_OUT follows SEL each cycle.
    - CLR_IN=1 forces SEL_OUT=0 and takes priority over SEL.
    - A DEC rising edge (DEC=1, previous DEC=0) -> JUDGE and pulses DEC_OUT for one cycle. SEL_OUT freezes.
    - A timeout -> WRONG.
    - A DEC edge and a timeout in the same cycle -> JUDGE; the DEC edge wins.
  - JUDGE=4: JUDG_IN=01 -> CORRECT; JUDG_IN=10 -> WRONG; 00 and 11 -> stay.
  - CORRECT=5 (one cycle): Q_CNT+1. If the new Q_CNT==NUM_Q -> CLEAR, else QUESTION.
  - WRONG=6 (one cycle):
    - HP_OUT-1, saturating at 0, and Q_CNT+1.
    - If the new HP_OUT==0 -> GAMEOVER; this has priority over clear.
    - Else if the new Q_CNT==NUM_Q -> CLEAR.
    - Else QUESTION.
  - CLEAR=7: CLR_OUT=1. READY_IN=1 -> IDLE.
  - GAMEOVER=8: READY_IN=1 -> IDLE.
- Codes 9..15 are illegal and return to IDLE on the next cycle.
- Timer:
  - The divider counts 0..SEC_DIV-1, only in INPUT.
  - Wrap produces a tick; each tick decrements TIME_LEFT.
  - A tick with TIME_LEFT==1 is a timeout.
  - TIME_LIMIT=0: no ticks are acted on, TIME_LEFT holds 0 and no timeout occurs.

## Timing
- Reset values: STATE=0, READY_OUT=0, SEL_OUT=0, DEC_OUT=0, CLR_OUT=0, HP_OUT=0, Q_CNT=0, TIME_LEFT=0, divider=0, DEC history=0.
- Reset asserted mid-game returns to IDLE immediately (asynchronously); state is lost.
- All outputs are registered; STATE changes one edge after the triggering input is sampled.
- DEC_OUT is high exactly in the first cycle of JUDGE.
- A DEC held from QUESTION into INPUT does not count as an edge; the history register is updated in every state.
- Timeout latency: TIME_LIMIT*SEC_DIV cycles after entering INPUT, then WRONG on the next edge.
- Q_CNT and HP_OUT update on the edge leaving CORRECT or WRONG.

## Structure
- Shared package game_pkg:
  - state codes as a 4-bit enum;
  - JUDG codes (JUDG_PEND, JUDG_OK, JUDG_NG).
- Sub-module sec_timer, parameters SEC_DIV and TIME_LIMIT:
  - inputs: load and enable;
  - outputs: TIME_LEFT and a timeout pulse.
- The FSM, selection latch and counters stay in game_ctrl_param.

## Test plan
Parameters SEC_DIV=4, TIME_LIMIT=3, NUM_Q=2, HP_INIT=2 unless noted.
- Reset, then READY_IN=1 -> STATE=1, HP_OUT=2, Q_CNT=0. Then OK_IN=1 then QUE_IN=1 -> STATE=3, TIME_LEFT=3.
- SEL=5 then CLR_IN=1 -> SEL_OUT=5 then 0. DEC rising edge -> one-cycle DEC_OUT and STATE=4.
- Two rounds with JUDG_IN=01 -> Q_CNT=2, STATE=7, CLR_OUT=1. READY_IN=1 -> STATE=0.
- No DEC in INPUT -> TIME_LEFT 3,2,1 at 4-cycle steps, then STATE=6 after 12 cycles, HP_OUT=1.
- JUDG_IN=10 twice -> HP_OUT=0, STATE=8. With NUM_Q=1, a single JUDG_IN=10 and HP_INIT=1 -> GAMEOVER, not CLEAR.
- RST low during JUDGE -> all outputs at reset values. DEC edge on the timeout cycle -> STATE=4, not 6.
